// File: rtl/pipeline_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module : pipeline_pkg
// Brief  : Shared sequencer state encoding and RV32I opcode constants.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [6:0] R_TYPE  = 7'b0110011;
    localparam logic [6:0] I_TYPE  = 7'b0010011;
    localparam logic [6:0] STORE   = 7'b0100011;
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] BRANCH  = 7'b1100011;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] FENCES  = 7'b0001111;
    localparam logic [6:0] SYSCALL = 7'b1110011;

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_IWAIT) || (s == ST_DWAIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : pipeline_sequencer_if
// Brief  : Hazard/handshake inputs and stage control outputs of the sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipeline_sequencer_if;
    import pipeline_pkg::*;

    logic   hazard_stall;
    logic   branch_taken;
    logic   imem_ready;
    logic   exe_mem_mem_op;
    logic   dmem_ready;
    logic   wb_syscall;
    logic   resume;

    logic   pc_en;
    logic   if_id_en;
    logic   id_exe_en;
    logic   exe_mem_en;
    logic   mem_wb_en;
    logic   if_id_flush;
    logic   id_exe_flush;
    logic   exe_mem_flush;
    logic   imem_req;
    logic   dmem_req;
    logic   halted;
    logic   mem_timeout;
    state_t state;

    modport master (
        output hazard_stall, branch_taken, imem_ready, exe_mem_mem_op,
               dmem_ready, wb_syscall, resume,
        input  pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
               if_id_flush, id_exe_flush, exe_mem_flush,
               imem_req, dmem_req, halted, mem_timeout, state
    );

    modport slave (
        input  hazard_stall, branch_taken, imem_ready, exe_mem_mem_op,
               dmem_ready, wb_syscall, resume,
        output pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
               if_id_flush, id_exe_flush, exe_mem_flush,
               imem_req, dmem_req, halted, mem_timeout, state
    );

endinterface

`default_nettype wire

// File: rtl/pipeline_sequencer_watchdog.sv
//------------------------------------------------------------------------------
// Module : seq_wait_watchdog
// Brief  : Consecutive memory-wait counter with sticky timeout flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_wait_watchdog #(
    parameter int MAX_WAIT = 255
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_in_wait,
    input  wire logic i_wait_cond,
    output logic      o_expire,
    output logic      o_timeout
);

    localparam int            c_cw  = $clog2(MAX_WAIT + 1);
    localparam logic [c_cw-1:0] c_max = c_cw'(MAX_WAIT);

    logic [c_cw-1:0] r_cnt;
    logic            r_timeout;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_in_wait) begin
            if (r_cnt != c_max) begin
                r_cnt <= r_cnt + c_cw'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Fires only while still stuck: a wait that resolves on the limit cycle is not a timeout.
    assign o_expire = i_in_wait && i_wait_cond && (r_cnt == c_max);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_timeout <= 1'b0;
        end else if (o_expire) begin
            r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;

endmodule

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
//------------------------------------------------------------------------------
// Module : pipeline_sequencer
// Brief  : Stall/flush sequencer for the 5-stage RV32I pipeline.
//          Optional PERF_CNT_EN adds saturating stall/flush counters.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  wire logic           clock,
    input  wire logic           reset,
    pipeline_sequencer_if.slave bus
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
`endif
);

    if ((MAX_WAIT < 1) || (CNT_W < 1)) begin : g_bad_cfg
        $error("pipeline_sequencer: MAX_WAIT and CNT_W must be >= 1");
    end

    state_t r_state;
    state_t w_state_nxt;

    logic w_pc_en, w_if_id_en, w_id_exe_en, w_exe_mem_en, w_mem_wb_en;
    logic w_if_id_flush, w_id_exe_flush, w_exe_mem_flush;
    logic w_imem_req, w_dmem_req, w_halted;
    logic w_dwait, w_wait_cond, w_branch_acc;
    logic w_expire, w_timeout;

    assign w_dwait = bus.exe_mem_mem_op && !bus.dmem_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_en         = 1'b0;
        w_if_id_en      = 1'b0;
        w_id_exe_en     = 1'b0;
        w_exe_mem_en    = 1'b0;
        w_mem_wb_en     = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_exe_flush  = 1'b0;
        w_exe_mem_flush = 1'b0;
        w_imem_req      = 1'b0;
        w_dmem_req      = 1'b0;
        w_halted        = 1'b0;
        w_wait_cond     = 1'b0;
        w_branch_acc    = 1'b0;

        if (!reset) begin
            w_state_nxt     = ST_RUN;
            w_if_id_flush   = 1'b1;
            w_id_exe_flush  = 1'b1;
            w_exe_mem_flush = 1'b1;
        end else if (r_state == ST_HALT) begin
            w_halted = 1'b1;
            if (bus.resume) begin
                w_state_nxt = ST_RUN;
            end
        end else begin
            w_imem_req = 1'b1;
            w_dmem_req = bus.exe_mem_mem_op && (r_state != ST_IWAIT);
            if (w_dwait) begin
                w_wait_cond = 1'b1;
                w_state_nxt = ST_DWAIT;
            end else if (bus.wb_syscall) begin
                // The WB instruction is the oldest in flight, so it halts ahead of an EX redirect.
                w_if_id_flush   = 1'b1;
                w_id_exe_flush  = 1'b1;
                w_exe_mem_flush = 1'b1;
                w_mem_wb_en     = 1'b1;
                w_state_nxt     = ST_HALT;
            end else if (bus.branch_taken) begin
                w_branch_acc   = 1'b1;
                w_pc_en        = 1'b1;
                w_if_id_en     = 1'b1;
                w_id_exe_en    = 1'b1;
                w_exe_mem_en   = 1'b1;
                w_mem_wb_en    = 1'b1;
                w_if_id_flush  = 1'b1;
                w_id_exe_flush = 1'b1;
                w_state_nxt    = ST_RUN;
            end else if (!bus.imem_ready) begin
                w_wait_cond     = 1'b1;
                w_exe_mem_en    = 1'b1;
                w_exe_mem_flush = 1'b1;
                w_mem_wb_en     = 1'b1;
                w_state_nxt     = ST_IWAIT;
            end else if (bus.hazard_stall) begin
                w_id_exe_en    = 1'b1;
                w_id_exe_flush = 1'b1;
                w_exe_mem_en   = 1'b1;
                w_mem_wb_en    = 1'b1;
                w_state_nxt    = ST_RUN;
            end else begin
                w_pc_en      = 1'b1;
                w_if_id_en   = 1'b1;
                w_id_exe_en  = 1'b1;
                w_exe_mem_en = 1'b1;
                w_mem_wb_en  = 1'b1;
                w_state_nxt  = ST_RUN;
            end
            if (w_expire) begin
                w_state_nxt = ST_HALT;
            end
        end
    end

    seq_wait_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clock       (clock),
        .reset       (reset),
        .i_in_wait   (is_wait_state(r_state)),
        .i_wait_cond (w_wait_cond),
        .o_expire    (w_expire),
        .o_timeout   (w_timeout)
    );

    assign bus.pc_en         = w_pc_en;
    assign bus.if_id_en      = w_if_id_en;
    assign bus.id_exe_en     = w_id_exe_en;
    assign bus.exe_mem_en    = w_exe_mem_en;
    assign bus.mem_wb_en     = w_mem_wb_en;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_exe_flush  = w_id_exe_flush;
    assign bus.exe_mem_flush = w_exe_mem_flush;
    assign bus.imem_req      = w_imem_req;
    assign bus.dmem_req      = w_dmem_req;
    assign bus.halted        = w_halted;
    assign bus.mem_timeout   = w_timeout;
    assign bus.state         = r_state;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_en && (r_state != ST_HALT) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_branch_acc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_pipeline_sequencer
// Brief  : Randomised scoreboard bench for pipeline_sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_sequencer;

    localparam int TB_MAX_WAIT = 3;
    localparam int TB_CNT_W    = 4;
    localparam int CNT_SAT     = (1 << TB_CNT_W) - 1;

    localparam int A_DW = 0, A_SYS = 1, A_BR = 2, A_IW = 3, A_HZ = 4, A_N = 5;

    logic clock;
    logic reset;

    pipeline_sequencer_if bus ();

`ifdef PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] flush_cnt;
`endif

    pipeline_sequencer #(
        .MAX_WAIT (TB_MAX_WAIT),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [13:0] v;
        int          stall;
        int          flush;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: mode 0..3 = RUN/IWAIT/DWAIT/HALT, wait-cycle tally, sticky flag.
    int m_state = 0;
    int m_wait  = 0;
    bit m_to    = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic drive(input bit rstn, input bit hs, input bit br, input bit ir,
                         input bit mo, input bit dr, input bit sc, input bit rs);
        logic [4:0] en;
        logic [2:0] fl;
        bit         ireq, dreq, hlt, to_now;
        int         act, nxt;
        exp_t       e;
        @(posedge clock);
        #1;
        reset              = rstn;
        bus.hazard_stall   = hs;
        bus.branch_taken   = br;
        bus.imem_ready     = ir;
        bus.exe_mem_mem_op = mo;
        bus.dmem_ready     = dr;
        bus.wb_syscall     = sc;
        bus.resume         = rs;

        en = 5'b0; fl = 3'b0; ireq = 0; dreq = 0; hlt = 0; to_now = 0;
        act = -1; nxt = m_state;
        if (!rstn) begin
            fl = 3'b111;
        end else if (m_state == 3) begin
            hlt = 1;
            nxt = rs ? 0 : 3;
        end else begin
            ireq = 1;
            dreq = mo && (m_state != 1);
            if (mo && !dr)  act = A_DW;
            else if (sc)    act = A_SYS;
            else if (br)    act = A_BR;
            else if (!ir)   act = A_IW;
            else if (hs)    act = A_HZ;
            else            act = A_N;
            // en = {pc, if_id, id_exe, exe_mem, mem_wb}; fl = {if_id, id_exe, exe_mem}
            case (act)
                A_DW:    begin en = 5'b00000; fl = 3'b000; nxt = 2; end
                A_SYS:   begin en = 5'b00001; fl = 3'b111; nxt = 3; end
                A_BR:    begin en = 5'b11111; fl = 3'b110; nxt = 0; end
                A_IW:    begin en = 5'b00011; fl = 3'b001; nxt = 1; end
                A_HZ:    begin en = 5'b00111; fl = 3'b010; nxt = 0; end
                default: begin en = 5'b11111; fl = 3'b000; nxt = 0; end
            endcase
            if ((act == A_DW || act == A_IW) && (m_state == 1 || m_state == 2) &&
                (m_wait == TB_MAX_WAIT)) begin
                to_now = 1;
                nxt    = 3;
            end
        end

        e.v     = {en, fl, ireq, dreq, hlt, m_to, 2'(m_state)};
        e.stall = m_stall;
        e.flush = m_flush;
        sb.push_back(e);

        if (!rstn) begin
            m_state = 0; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!en[4] && m_state != 3 && m_stall < CNT_SAT) m_stall++;
            if (act == A_BR && m_flush < CNT_SAT) m_flush++;
            m_wait  = (m_state == 1 || m_state == 2) ? m_wait + 1 : 0;
            m_to    = m_to | to_now;
            m_state = nxt;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 1, 0, 1, 0, 0);
    endtask

    logic [13:0] got;
    exp_t        me;

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            me  = sb.pop_front();
            got = {bus.pc_en, bus.if_id_en, bus.id_exe_en, bus.exe_mem_en, bus.mem_wb_en,
                   bus.if_id_flush, bus.id_exe_flush, bus.exe_mem_flush,
                   bus.imem_req, bus.dmem_req, bus.halted, bus.mem_timeout, bus.state};
            checks++;
            if (got !== me.v) begin
                failures++;
                $display("FAIL outputs t=%0t got=%b want=%b (en5 fl3 ireq dreq halt tmo st2)",
                         $time, got, me.v);
            end
`ifdef PERF_CNT_EN
            checks++;
            if ((int'(stall_cnt) != me.stall) || (int'(flush_cnt) != me.flush)) begin
                failures++;
                $display("FAIL perf_cnt t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         $time, stall_cnt, flush_cnt, me.stall, me.flush);
            end
`endif
        end
    end

    initial begin
        reset              = 1'b0;
        bus.hazard_stall   = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.imem_ready     = 1'b1;
        bus.exe_mem_mem_op = 1'b0;
        bus.dmem_ready     = 1'b1;
        bus.wb_syscall     = 1'b0;
        bus.resume         = 1'b0;

        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 2; i++) drive(1, 1, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, i == 1, 0, 0, 1, 0, 0);
        idle(1);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 1, 1, 0, 0);
        idle(1);
        // Data-side watchdog, halt, ignored-until-resume, then resume.
        for (int i = 0; i < 6; i++) drive(1, 0, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 1, 0, 1);
        idle(2);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 1, 0, 1, 0, 0);
        // Fetch-side watchdog.
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 1, 0, 1);
        drive(1, 0, 0, 1, 0, 1, 1, 0);
        drive(1, 0, 0, 1, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 1, 0, 1, 0, 1, 0, 0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) != 0,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 25);
        end

        @(negedge clock);
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Combines three inputs into per-stage register enables and flushes:
  - the RAW hazard stall from the ID-stage interlock;
  - branch/jump redirects resolved in EX;
  - instruction and data memory ready handshakes.
- An FSM tracks memory waits, SYSCALL halt and a wait-timeout watchdog.

Parameters:
- MAX_WAIT, 255, maximum consecutive cycles in IWAIT or DWAIT before timeout (>=1).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; reset==0 resets
- hazard_stall  in  1  RAW interlock stall for the instruction in ID
- branch_taken  in  1  EX-stage redirect (taken branch, JAL, JALR)
- imem_ready  in  1  fetch data valid this cycle
- exe_mem_mem_op  in  1  MEM stage holds a load or store
- dmem_ready  in  1  data access completes this cycle
- wb_syscall  in  1  valid SYSCALL opcode (1110011) in WB
- resume  in  1  leave HALT
- pc_en  out  1  PC register update
- if_id_en, id_exe_en, exe_mem_en, mem_wb_en  out  1 each  pipeline register enables
- if_id_flush, id_exe_flush, exe_mem_flush  out  1 each  load a bubble (overrides hold)
- imem_req  out  1  fetch request; PC held stable while high and not ready
- dmem_req  out  1  data request = exe_mem_mem_op while in RUN or DWAIT
- halted  out  1  state==HALT
- mem_timeout  out  1  sticky watchdog flag
- state  out  2  RUN=0, IWAIT=1, DWAIT=2, HALT=3

Behaviour:
- Enables and flushes are combinational from the registered state and the current inputs.
- While reset==0:
  - state<=RUN, wait counter<=0, mem_timeout<=0;
  - outputs forced: all enables 0, all flushes 1, imem_req=0, dmem_req=0, halted=0.
- Evaluation priority: HALT > DWAIT condition > branch_taken > IWAIT condition > hazard_stall > normal.
- Normal (RUN, no events): all enables 1, flushes 0, imem_req=1.
- DWAIT condition (exe_mem_mem_op & ~dmem_ready, in RUN/IWAIT/DWAIT):
  - all enables 0; flushes 0; go or stay in DWAIT.
  - WB holds; the repeated regfile write is idempotent.
  - Exit when dmem_ready=1: the same cycle applies the lower-priority rules and next state is derived from them.
- branch_taken (no DWAIT):
  - pc_en=1; if_id_flush=1; id_exe_flush=1; downstream enables 1; state RUN.
  - Wins over hazard_stall because the ID instruction is wrong-path.
  - Wins over ~imem_ready because the in-flight fetch is discarded; imem_req stays 1 with the new PC next cycle.
- IWAIT condition (~imem_ready):
  - pc_en=0; if_id_en=0; id_exe_en=0 (EX frozen so the branch in EX is retained);
  - exe_mem_flush=1; mem_wb_en=1; go or stay in IWAIT.
  - On imem_ready=1, apply RUN rules the same cycle.
- hazard_stall:
  - pc_en=0; if_id_en=0; id_exe_flush=1; exe_mem_en=mem_wb_en=1; state RUN.
- wb_syscall in RUN/IWAIT (no DWAIT):
  - entry cycle: if_id_flush, id_exe_flush, exe_mem_flush=1; mem_wb_en=1; next state HALT.
  - in HALT: enables 0, requests 0, halted=1.
  - resume=1 -> RUN next cycle.
  - resume is ignored outside HALT.
- Watchdog:
  - The wait counter increments each IWAIT/DWAIT cycle and clears on any other state.
  - When count==MAX_WAIT with the wait condition still true: mem_timeout<=1 (sticky until reset) and next state HALT.
- Reset asserted mid-wait aborts immediately; the external memory must tolerate request drop.

Optional Feature:
- PERF_CNT_EN defined adds ports stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0], both reset 0 and saturating at all-ones:
  - stall_cnt +1 each cycle with pc_en=0 and state!=HALT;
  - flush_cnt +1 each cycle branch_taken is accepted.
- Undefined: the ports and logic are absent.

Decomposition:
- Package pipeline_pkg holds:
  - the state enum (2-bit);
  - opcode localparams (R_TYPE, I_TYPE, STORE, LOAD, BRANCH, JALR, JAL, AUIPC, LUI, FENCES, SYSCALL), shared with the interlock and decoder.
- Optional sub-module: seq_wait_watchdog (counter + compare + sticky flag).

Test Plan:
- Reset held low 3 cycles, then high, no events -> first cycle: all enables 1, state=0, imem_req=1.
- hazard_stall=1 for 2 cycles -> pc_en=0, if_id_en=0, id_exe_flush=1 both cycles; exe_mem_en=1.
- imem_ready=0 for 4 cycles with branch_taken=1 in the 2nd cycle -> branch wins that cycle (pc_en=1, if_id_flush=id_exe_flush=1, state 0); other 3 cycles state=1, exe_mem_flush=1, pc_en=0.
- exe_mem_mem_op=1, dmem_ready=0 for 5 cycles, simultaneous hazard_stall=1 -> all enables 0, state=2; 6th cycle dmem_ready=1 -> hazard rules apply, state=0.
- MAX_WAIT=3, dmem_ready held 0 -> after 3 DWAIT cycles mem_timeout=1, state=3, halted=1; resume -> state=0 with mem_timeout still 1.
- PERF_CNT_EN with CNT_W=4: 20 stall cycles -> stall_cnt saturates at 15.
